// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM link constants, FSM state type and counter-width helper.
package pwm_pkg;
   localparam int POS_W  = 10;
   localparam int PERIOD = 2048;
   typedef enum logic {IDLE, RUN} state_t;
   function automatic int cnt_w(input int period);
      return $clog2(period);
   endfunction
endpackage

// File: rtl/pwm_frame_counter.sv
// pwm_frame_counter: frame position counter, held at 0 while idle, wraps PERIOD-1 -> 0.
module pwm_frame_counter
   import pwm_pkg::*;
#(
   parameter int PERIOD = pwm_pkg::PERIOD,
   parameter int CNT_W  = cnt_w(PERIOD)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign wrap = run && cnt_q == LAST;
   assign cnt  = cnt_q;
   always_comb cnt_d = (!run || wrap) ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk)
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
endmodule

// File: rtl/pwm_transmitter.sv
// pwm_transmitter: position word -> fixed-period PWM with frame-aligned shadow update.
// Optional macro PWM_TX_GATE_EN adds gate_en, sampled at frame boundaries to blank frames.
module pwm_transmitter
   import pwm_pkg::*;
#(
   parameter int POS_W  = pwm_pkg::POS_W,
   parameter int PERIOD = pwm_pkg::PERIOD,
   parameter int CNT_W  = cnt_w(PERIOD)
) (
`ifdef PWM_TX_GATE_EN
   input  logic             gate_en,
`endif
   input  logic             clk,
   input  logic             reset,
   input  logic [POS_W-1:0] pos_data,
   input  logic             pos_valid,
   output logic             pos_ready,
   output logic             pwm,
   output logic             frame_start,
   output logic             busy
);
   state_t           state_q, state_d;
   logic [POS_W-1:0] shadow_q, shadow_d, active_q, active_d;
   logic             pending_q, pending_d, gate_q, gate_d;
   logic             pwm_q, pwm_d, frame_start_q, frame_start_d, busy_q, busy_d;
   logic [CNT_W-1:0] cnt;
   logic             wrap, accept, boundary, gate_in;
`ifdef PWM_TX_GATE_EN
   assign gate_in = gate_en;
`else
   assign gate_in = 1'b1;
`endif
   pwm_frame_counter #(.PERIOD(PERIOD), .CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .run   (state_q == RUN),
      .cnt   (cnt),
      .wrap  (wrap)
   );
   assign accept   = pos_valid && !pending_q;
   assign boundary = (state_q == IDLE && pending_q) || wrap;
   // Outputs are one edge behind cnt, so frame cycle 0 appears the edge after the boundary.
   always_comb begin
      state_d       = (state_q == IDLE && pending_q) ? RUN : state_q;
      pending_d     = accept ? 1'b1 : boundary ? 1'b0 : pending_q;
      shadow_d      = accept ? pos_data : shadow_q;
      active_d      = (boundary && pending_q) ? shadow_q : active_q;
      gate_d        = boundary ? gate_in : gate_q;
      pwm_d         = state_q == RUN && gate_q && cnt < CNT_W'(active_q);
      frame_start_d = state_q == RUN && cnt == '0;
      busy_d        = state_d == RUN;
   end
   always_ff @(posedge clk)
      if (reset) begin
         state_q       <= IDLE;
         shadow_q      <= '0;
         active_q      <= '0;
         pending_q     <= 1'b0;
         gate_q        <= 1'b1;
         pwm_q         <= 1'b0;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         pending_q     <= pending_d;
         gate_q        <= gate_d;
         pwm_q         <= pwm_d;
         frame_start_q <= frame_start_d;
         busy_q        <= busy_d;
      end
   assign pos_ready   = !pending_q;
   assign pwm         = pwm_q;
   assign frame_start = frame_start_q;
   assign busy        = busy_q;
endmodule

// File: tb/tb_pwm_transmitter.sv
// tb_pwm_transmitter: directed frame measurements plus random offers against a frame-arithmetic model.
module tb_pwm_transmitter;
   import pwm_pkg::*;
   localparam int P = PERIOD;
   logic clk = 0, reset = 1, pos_valid = 0, gate_en = 1;
   logic [POS_W-1:0] pos_data = '0;
   logic pwm, frame_start, busy, pos_ready;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   pwm_transmitter dut (
`ifdef PWM_TX_GATE_EN
      .gate_en     (gate_en),
`endif
      .clk         (clk),
      .reset       (reset),
      .pos_data    (pos_data),
      .pos_valid   (pos_valid),
      .pos_ready   (pos_ready),
      .pwm         (pwm),
      .frame_start (frame_start),
      .busy        (busy)
   );
   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
      end
   endtask
   // Model: frames start t0 edges after entry; output at edge e shows frame position (e-1-t0) mod P.
   int e = 0, t0 = 0, m_shadow = 0, m_act = 0, ph;
   bit m_run = 0, m_pend = 0, m_gate = 1, acc, bnd, gsample;
   bit exp_pwm = 0, exp_fs = 0, exp_busy = 0, checking = 0;
   always @(posedge clk) begin
      e++;
`ifdef PWM_TX_GATE_EN
      gsample = gate_en;
`else
      gsample = 1;
`endif
      if (reset) begin
         m_run = 0; m_pend = 0; m_gate = 1; m_shadow = 0; m_act = 0;
         exp_pwm = 0; exp_fs = 0; exp_busy = 0;
      end else begin
         ph = m_run ? (e - 1 - t0) % P : 0;
         exp_pwm = m_run && m_gate && ph < m_act;
         exp_fs = m_run && ph == 0;
         acc = pos_valid && !m_pend;
         bnd = (!m_run && m_pend) || (m_run && (e - t0) % P == 0);
         if (!m_run && m_pend) begin m_run = 1; t0 = e; end
         if (bnd) begin
            if (m_pend) m_act = m_shadow;
            m_pend = 0;
            m_gate = gsample;
         end
         if (acc) begin m_shadow = int'(pos_data); m_pend = 1; end
         exp_busy = m_run;
      end
   end
   always @(negedge clk)
      if (checking) begin
         chk("pwm", pwm, exp_pwm);
         chk("frame_start", frame_start, exp_fs);
         chk("busy", busy, exp_busy);
         chk("pos_ready", pos_ready, !m_pend);
      end
   task automatic offer(input int d);
      int n = 0;
      pos_data = POS_W'(d);
      pos_valid = 1;
      while (!pos_ready && n < 4 * P) begin @(negedge clk); n++; end
      chk("offer_ready", pos_ready, 1);
      @(negedge clk);
      pos_valid = 0;
   endtask
   task automatic measure(input string tag, input int exp);
      int n = 0, hi = 0;
      while (!frame_start && n < 5000) begin @(negedge clk); n++; end
      chk({tag, "_fs"}, frame_start, 1);
      for (int i = 0; i < P; i++) begin hi += pwm; @(negedge clk); end
      chk(tag, hi, exp);
   endtask
   initial begin
      int hi;
      @(negedge clk);
      checking = 1;
      chk("rst_pwm", pwm, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", pos_ready, 1);
      chk("rst_fs", frame_start, 0);
      reset = 0;
      repeat (3) @(negedge clk);
      chk("ready_before", pos_ready, 1);
      offer(5);
      chk("lat0", frame_start, 0);
      @(negedge clk);
      chk("lat1", frame_start, 0);
      @(negedge clk);
      chk("lat2_fs", frame_start, 1);
      chk("lat2_pwm", pwm, 1);
      measure("w5", 5);
      measure("w5b", 5);
      offer(0);
      measure("w0", 0);
      measure("w0b", 0);
      offer(1023);
      measure("w1023", 1023);
      offer(5);
      measure("w5c", 5);
      repeat (100) @(negedge clk);
      offer(300);
      chk("stall", pos_ready, 0);
      offer(700);
      measure("w300", 300);
      measure("w700", 700);
      offer(10);
      measure("w10_pre", 10);
      repeat (2) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("mid_rst_pwm", pwm, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", pos_ready, 1);
      hi = 0;
      for (int i = 0; i < 3000; i++) begin hi += pwm | frame_start; @(negedge clk); end
      chk("post_rst_quiet", hi, 0);
`ifdef PWM_TX_GATE_EN
      offer(50);
      measure("g50", 50);
      gate_en = 0;
      measure("g_off", 0);
      gate_en = 1;
      @(negedge clk);
      measure("g_on", 50);
`endif
      for (int i = 0; i < 12000; i++) begin
         pos_valid = $urandom_range(0, 399) == 0;
         case ($urandom_range(0, 3))
            0: pos_data = '0;
            1: pos_data = '1;
            default: pos_data = POS_W'($urandom);
         endcase
`ifdef PWM_TX_GATE_EN
         gate_en = $urandom_range(0, 3) != 0;
`endif
         @(negedge clk);
      end
      pos_valid = 0;
      @(negedge clk);
      checking = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
